// File: rtl/bank_ram_pkg.sv
// bank_ram_pkg: shared sizes, FSM state type and packed bank data type for bank_ram_slave
package bank_ram_pkg;
  localparam int NUM_BANKS = 5;
  localparam int ADDR_WIDTH = 9;
  localparam int DATA_WIDTH = 32;
  typedef enum logic {IDLE, WDATA} state_t;
  typedef logic [NUM_BANKS*DATA_WIDTH-1:0] bank_data_t;
endpackage

// File: rtl/bank_sram_sp.sv
// bank_sram_sp: single-port 2**ADDR_WIDTH x DATA_WIDTH RAM (clk, en, we, addr, wdata in; registered rdata out)
module bank_sram_sp #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (en && we) mem[addr] <= wdata;
    if (en && !we) rdata <= mem[addr];
  end
endmodule

// File: rtl/bank_ram_slave.sv
// bank_ram_slave: command/data slave over NUM_BANKS lock-step SRAM banks (cmd_*/w* in, cmd_ready/wready/rvalid/rdata out)
module bank_ram_slave #(
  parameter int NUM_BANKS  = bank_ram_pkg::NUM_BANKS,
  parameter int ADDR_WIDTH = bank_ram_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = bank_ram_pkg::DATA_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rw,
  input  logic [NUM_BANKS-1:0]            cmd_mask,
  input  logic [ADDR_WIDTH-1:0]           cmd_addr,
  input  logic                            wvalid,
  output logic                            wready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);
  import bank_ram_pkg::*;
  state_t state, state_nxt;
  logic rd_acc, wr_acc, wr_fire, v0, v1;
  logic [ADDR_WIDTH-1:0] waddr, bank_addr;
  logic [NUM_BANKS-1:0] wmask, m0, m1, bank_en;
  logic [NUM_BANKS*DATA_WIDTH-1:0] q, d1, dm;
  assign cmd_ready = (state == IDLE);
  assign wready = (state == WDATA);
  assign rd_acc = cmd_ready & cmd_valid & ~cmd_rw;
  assign wr_acc = cmd_ready & cmd_valid & cmd_rw;
  assign wr_fire = wready & wvalid;
  assign bank_addr = wr_fire ? waddr : cmd_addr;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE) ? (wr_acc ? WDATA : IDLE) : (wvalid ? IDLE : WDATA);
  end
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign bank_en[b] = (rd_acc & cmd_mask[b]) | (wr_fire & wmask[b]);
    assign dm[b*DATA_WIDTH +: DATA_WIDTH] = m1[b] ? d1[b*DATA_WIDTH +: DATA_WIDTH] : '0;
    bank_sram_sp #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_sram (
      .clk   (clk),
      .en    (bank_en[b]),
      .we    (wr_fire),
      .addr  (bank_addr),
      .wdata (wdata[b*DATA_WIDTH +: DATA_WIDTH]),
      .rdata (q[b*DATA_WIDTH +: DATA_WIDTH])
    );
  end
  // v0/m0 track the SRAM access itself; v1/d1 is the stage-1 capture of the
  // SRAM output; rvalid/rdata is stage 2, where unselected banks are zeroed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      waddr <= '0;
      wmask <= '0;
      v0 <= 1'b0;
      m0 <= '0;
      v1 <= 1'b0;
      m1 <= '0;
      d1 <= '0;
      rvalid <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      if (wr_acc) begin
        waddr <= cmd_addr;
        wmask <= cmd_mask;
      end
      v0 <= rd_acc;
      if (rd_acc) m0 <= cmd_mask;
      v1 <= v0;
      if (v0) begin
        m1 <= m0;
        d1 <= q;
      end
      rvalid <= v1;
      if (v1) rdata <= dm;
    end
  end
endmodule

// File: tb/tb_bank_ram_slave.sv
// tb_bank_ram_slave: scoreboard bench for bank_ram_slave
module tb_bank_ram_slave;
  import bank_ram_pkg::*;
  typedef struct {bank_data_t d; int due;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_rw = 1'b0, wvalid = 1'b0;
  logic [NUM_BANKS-1:0] cmd_mask = '0;
  logic [ADDR_WIDTH-1:0] cmd_addr = '0;
  bank_data_t wdata = '0;
  logic cmd_ready, wready, rvalid;
  bank_data_t rdata;
  logic [DATA_WIDTH-1:0] mm [NUM_BANKS][2**ADDR_WIDTH];
  exp_t sb[$];
  exp_t e;
  int cyc = 0, n_checks = 0, n_errors = 0;
  bank_ram_slave dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_mask(cmd_mask), .cmd_addr(cmd_addr), .wvalid(wvalid), .wready(wready),
    .wdata(wdata), .rvalid(rvalid), .rdata(rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && rvalid) begin
      if (sb.size() == 0) check("spurious_rvalid", 160'd1, 160'd0);
      else begin
        e = sb.pop_front();
        check("rdata", rdata, e.d);
        check("rd_latency", 160'(cyc), 160'(e.due));
      end
    end
  end
  task automatic rd(input logic [ADDR_WIDTH-1:0] a, input logic [NUM_BANKS-1:0] m);
    bank_data_t x;
    x = '0;
    for (int b = 0; b < NUM_BANKS; b++) if (m[b]) x[b*DATA_WIDTH +: DATA_WIDTH] = mm[b][a];
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = a; cmd_mask = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sb.push_back('{x, cyc + 2});
  endtask
  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [NUM_BANKS-1:0] m, input bank_data_t d, input int hold);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = a; cmd_mask = m;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      check("hold_wready", 160'(wready), 160'd1);
      check("hold_cmd_ready", 160'(cmd_ready), 160'd0);
      @(posedge clk); #1;
    end
    wvalid = 1'b1; wdata = d;
    @(posedge clk); #1;
    wvalid = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) if (m[b]) mm[b][a] = d[b*DATA_WIDTH +: DATA_WIDTH];
  endtask
  initial begin
    for (int b = 0; b < NUM_BANKS; b++) for (int a = 0; a < 2**ADDR_WIDTH; a++) mm[b][a] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rst_cmd_ready", 160'(cmd_ready), 160'd1);
      check("rst_wready", 160'(wready), 160'd0);
      check("rst_rvalid", 160'(rvalid), 160'd0);
      check("rst_rdata", rdata, 160'd0);
      @(posedge clk); #1;
    end
    wr(9'h1A0, 5'b11111, {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, 0);
    rd(9'h1A0, 5'b11111);
    rd(9'h1A0, 5'b00101);
    for (int a = 0; a < 4; a++) wr(9'(a), 5'b11111, {5{32'h10 + 32'(a)}}, 0);
    for (int a = 0; a < 4; a++) rd(9'(a), 5'b11111);
    repeat (4) @(posedge clk); #1;
    wr(9'h1A0, 5'b00010, {32'hE4, 32'hE3, 32'hE2, 32'hB1, 32'hE0}, 3);
    rd(9'h1A0, 5'b11111);
    wr(9'h003, 5'b00000, {5{32'hDEAD_BEEF}}, 1);
    rd(9'h003, 5'b00000);
    rd(9'h003, 5'b11111);
    rd(9'h002, 5'b11011);
    wr(9'h002, 5'b11111, {5{32'h5A5A_0002}}, 0);
    rd(9'h002, 5'b11111);
    repeat (4) @(posedge clk); #1;
    rd(9'h1A0, 5'b11111);
    cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 9'h1A0; cmd_mask = 5'b11111;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("pre_rst_wready", 160'(wready), 160'd1);
    rst = 1'b1;
    sb.delete();
    wvalid = 1'b1; wdata = {5{32'hFFFF_FFFF}};
    #1;
    check("async_rst_cmd_ready", 160'(cmd_ready), 160'd1);
    check("async_rst_wready", 160'(wready), 160'd0);
    check("async_rst_rvalid", 160'(rvalid), 160'd0);
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("post_rst_cmd_ready", 160'(cmd_ready), 160'd1);
    check("post_rst_wready", 160'(wready), 160'd0);
    repeat (3) @(posedge clk); #1;
    rd(9'h1A0, 5'b11111);
    rd(9'h000, 5'b10001);
    repeat (5) @(posedge clk); #1;
    check("sb_drain", 160'(sb.size()), 160'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/bank_ram_slave.md
# bank_ram_slave

Slave-side responder for the banked scratch memory command/data protocol. Accepts read and write commands from one master, stores data in NUM_BANKS single-port SRAM banks addressed in lock-step, and returns masked read data through a fixed-latency pipeline. Sits between the datapath controller, which acts as master, and the physical bank macros.

## Interface
- NUM_BANKS, 5, number of banks addressed by one command
- ADDR_WIDTH, 9, per-bank word address width; bank depth is 2**ADDR_WIDTH
- DATA_WIDTH, 32, word width per bank
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command request valid
- cmd_ready  output  1  slave accepts a command this cycle
- cmd_rw  input  1  0 = read, 1 = write
- cmd_mask  input  NUM_BANKS  banks taking part in the command
- cmd_addr  input  ADDR_WIDTH  word address, shared by all banks
- wvalid  input  1  write data valid
- wready  output  1  slave accepts write data this cycle
- wdata  input  NUM_BANKS x DATA_WIDTH  packed write data; slice b goes to bank b
- rvalid  output  1  read data valid; one-cycle pulse, no back-pressure
- rdata  output  NUM_BANKS x DATA_WIDTH  packed read data

## Operation
- The FSM has two states: IDLE and WDATA.
- IDLE:
  - cmd_ready = 1, wready = 0.
  - Accepted read (cmd_valid & ~cmd_rw): all masked banks are enabled for a read at cmd_addr in the same cycle. The mask is pushed into a 2-stage read pipeline. The FSM stays in IDLE.
  - Accepted write: cmd_addr and cmd_mask are latched and the FSM moves to WDATA.
- WDATA:
  - cmd_ready = 0, wready = 1.
  - On wvalid, each bank b with mask[b] = 1 writes wdata[b] at the latched address. The FSM returns to IDLE.
  - wvalid presented while in IDLE is ignored and is not consumed.
- Read pipeline:
  - Stage 1 is the SRAM output register.
  - Stage 2 registers rdata and rvalid.
  - rdata slice b is the bank output when mask[b] = 1, otherwise 0.
- Empty mask (0): the command is still accepted and completes normally. A read returns rvalid with all-zero rdata. A write consumes one wdata beat and modifies nothing.
- Back-to-back reads sustain one command per cycle.
- A read in flight when a write command is accepted completes unaffected; its SRAM access has already happened.
- Read-after-write to the same address returns the new data. Ordering is guaranteed because the next command is accepted only after the write commits.
- Reset during WDATA drops the pending write. Reset also clears the read pipeline. SRAM contents are not cleared by reset.

## Timing
- Reset values: cmd_ready = 1, wready = 0, rvalid = 0, rdata = 0, state = IDLE, pipeline valids = 0.
- Read latency: command handshake at edge N gives rvalid = 1 and rdata valid during the cycle following edge N+2. rvalid is high for exactly one cycle per read.
- Write: command at edge N, data earliest at edge N+1. The data is readable by a read command accepted at edge N+2 or later.
- Write throughput: minimum 2 cycles per write. Read throughput: 1 per cycle.
- cmd_ready and wready are functions of state only; there is no combinational path from any input.

## Structure
- Package bank_ram_pkg holds:
  - NUM_BANKS, ADDR_WIDTH, DATA_WIDTH defaults
  - the state enum typedef (IDLE, WDATA)
  - a typedef for the packed bank data vector
- Sub-module bank_sram_sp: one single-port 2**ADDR_WIDTH x DATA_WIDTH RAM with en, we, addr, wdata and a registered rdata. It is instantiated NUM_BANKS times by a generate loop.

## Test plan
- Reset, then idle: cmd_ready = 1, wready = 0, rvalid = 0, rdata = 0 on every cycle.
- Write mask 5'b11111, addr 0x1A0, wdata = {32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0}, then read the same address with mask 5'b11111 -> rvalid 2 cycles after the read handshake, with the same data back.
- Read addr 0x1A0 with mask 5'b00101 -> rdata banks 0 and 2 = 32'hA0 and 32'hA2, banks 1, 3 and 4 = 0.
- Four back-to-back reads at addr 0..3, previously written with 32'h10+addr in all banks -> four consecutive rvalid pulses carrying the matching data, in order.
- Write command, then hold wvalid low 3 cycles -> wready stays 1 and cmd_ready stays 0. Then wvalid with mask 5'b00010 -> only bank 1 changes, verified by a read-back.
- Write command accepted, assert rst before wvalid -> FSM returns to IDLE and the target word is unchanged on read-back. A read in flight during the reset produces no rvalid.
